// File: rtl/zero_count_scheduler_if.sv
// Bundle between two requesters, a result consumer and the shared
// zero-counting engine.
//   req0/data0/gnt0 : requester 0 word handshake (gnt is combinational)
//   req1/data1/gnt1 : requester 1 word handshake
//   busy            : engine not idle
//   res_valid/res_ready/res_count/res_id : result handshake, tagged by requester
// Modports: master = requesters + consumer side, slave = the scheduler.
interface zero_count_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_id;

  modport master (
    output req0, data0, req1, data1, res_ready,
    input  gnt0, gnt1, busy, res_valid, res_count, res_id
  );

  modport slave (
    input  req0, data0, req1, data1, res_ready,
    output gnt0, gnt1, busy, res_valid, res_count, res_id
  );
endinterface

// File: rtl/zero_count_scheduler.sv
// Shared bit-serial zero counter with two round-robin requesters.
// A granted word is captured, its zero bits are counted one per cycle over
// WIDTH cycles, and the count is returned with the requester id through a
// valid/ready result port.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : zero_count_scheduler_if.slave (requests, grants, busy, result)
module zero_count_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  zero_count_scheduler_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic             last;

  logic             idle;
  logic             pick1;
  logic             take;
  logic [CNT_W-1:0] acc_nxt;

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  always_comb begin
    idle    = (state == IDLE);
    pick1   = bus.req1 & (~bus.req0 | ~last);
    take    = idle & (bus.req0 | bus.req1);
    acc_nxt = acc + {{(CNT_W-1){1'b0}}, ~shift[0]};
  end

  assign bus.gnt1 = idle & pick1;
  assign bus.gnt0 = idle & bus.req0 & ~pick1;
  assign bus.busy = ~idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift         <= '0;
      acc           <= '0;
      idx           <= '0;
      last          <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_count <= '0;
      bus.res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shift      <= pick1 ? bus.data1 : bus.data0;
            acc        <= '0;
            idx        <= '0;
            bus.res_id <= pick1;
            last       <= pick1;
            state      <= COUNT;
          end
        end
        COUNT: begin
          acc   <= acc_nxt;
          shift <= shift >> 1;
          idx   <= idx + 1'b1;
          // acc_nxt already includes the final bit, so publish it directly.
          if (idx == IDX_W'(WIDTH-1)) begin
            bus.res_count <= acc_nxt;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_scheduler.sv
module tb_zero_count_scheduler;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zero_count_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  zero_count_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a job occupies the engine from its grant cycle g
  // until the handshake; the result is visible from cycle g+WIDTH+1.
  bit job    = 0;
  int gcyc   = 0;
  int m_cnt  = 0;
  bit m_id   = 0;
  bit m_last = 1;

  int gid_q[$];
  int gcyc_q[$];
  int hcnt_q[$];
  int hid_q[$];
  int hcyc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    gid_q.delete(); gcyc_q.delete();
    hcnt_q.delete(); hid_q.delete(); hcyc_q.delete();
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance.
  task automatic step(input logic r, input logic q0, input logic [WIDTH-1:0] d0,
                      input logic q1, input logic [WIDTH-1:0] d1, input logic rr);
    bit g0, g1, ev;
    rst = r; bus.req0 = q0; bus.data0 = d0; bus.req1 = q1; bus.data1 = d1;
    bus.res_ready = rr;
    #1;
    g0 = 0; g1 = 0;
    if (!job) begin
      if (q0 && q1) begin g1 = (m_last == 1'b0); g0 = !g1; end
      else begin g0 = q0; g1 = q1; end
    end
    ev = job && (cyc >= gcyc + WIDTH + 1);
    check("gnt0", bus.gnt0, g0);
    check("gnt1", bus.gnt1, g1);
    check("busy", bus.busy, job);
    check("res_valid", bus.res_valid, ev);
    if (ev) begin
      check("res_count", bus.res_count, m_cnt);
      check("res_id", bus.res_id, m_id);
    end
    @(posedge clk); #1;
    if (r) begin
      job = 0; m_last = 1;
    end else if (job) begin
      if (ev && rr) begin
        job = 0;
        hcnt_q.push_back(m_cnt); hid_q.push_back(m_id); hcyc_q.push_back(cyc);
      end
    end else if (g0 || g1) begin
      job    = 1;
      gcyc   = cyc;
      m_id   = g1;
      m_last = g1;
      m_cnt  = WIDTH - $countones(g1 ? d1 : d0);
      gid_q.push_back(g1); gcyc_q.push_back(cyc);
    end
    cyc++;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bit p0, p1;
    logic [WIDTH-1:0] pd0, pd1;
    int n;

    rst = 1'b1; bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
    bus.res_ready = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_count", bus.res_count, 0);
    check("rst_id", bus.res_id, 0);
    check("rst_busy", bus.busy, 0);

    // Single request from requester 0.
    clear_logs();
    step(0, 1, 8'b00100100, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1);
    check("t1_grants", gid_q.size(), 1);
    check("t1_results", hcnt_q.size(), 1);
    if (hcnt_q.size() == 1) begin
      check("t1_count", hcnt_q[0], 6);
      check("t1_id", hid_q[0], 0);
      check("t1_latency", hcyc_q[0] - gcyc_q[0], WIDTH + 1);
    end

    // Requester 1 with backpressure; requester 0 waits meanwhile.
    clear_logs();
    step(0, 0, 0, 1, 8'b11011011, 0);
    for (int i = 0; i < 13; i++) step(0, 1, 8'h55, 0, 0, 0);
    check("t2_held", hcnt_q.size(), 0);
    check("t2_no_gnt", gid_q.size(), 1);
    step(0, 1, 8'h55, 0, 0, 1);
    step(0, 1, 8'h55, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 1);
    check("t2_results", hcnt_q.size(), 2);
    if (hcnt_q.size() == 2) begin
      check("t2_count1", hcnt_q[0], 2);
      check("t2_id1", hid_q[0], 1);
      check("t2_count0", hcnt_q[1], 4);
      check("t2_gap", gcyc_q[1] - hcyc_q[0], 1);
    end

    // Round-robin with both requesters held from reset.
    step(1, 1, 8'h00, 1, 8'hFF, 1);
    clear_logs();
    for (int i = 0; i < 35; i++) step(0, 1, 8'h00, 1, 8'hFF, 1);
    check("rr_grants", gid_q.size(), 4);
    if (gid_q.size() >= 3) begin
      check("rr_first", gid_q[0], 0);
      check("rr_second", gid_q[1], 1);
      check("rr_third", gid_q[2], 0);
    end
    if (hcnt_q.size() >= 2) begin
      check("rr_cnt0", hcnt_q[0], 8);
      check("rr_cnt1", hcnt_q[1], 0);
    end

    // Reset in the middle of a count.
    step(1, 0, 0, 0, 0, 1);
    clear_logs();
    step(0, 1, 8'hA5, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check("mid_valid", bus.res_valid, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_count", bus.res_count, 0);
    step(0, 1, 8'h01, 1, 8'h02, 1);
    check("mid_regrant", gid_q[gid_q.size()-1], 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 1);
    check("mid_results", hcnt_q.size(), 1);

    // Data change after grant is ignored.
    clear_logs();
    step(0, 1, 8'h0F, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0, 0, 1);
    check("dchg_results", hcnt_q.size(), 1);
    if (hcnt_q.size() == 1) check("dchg_count", hcnt_q[0], 4);

    // Back-to-back on requester 0; data refreshed only after each grant.
    clear_logs();
    d = 8'h3C;
    for (int i = 0; i < 50; i++) begin
      n = gid_q.size();
      step(0, 1, d, 0, 0, 1);
      if (gid_q.size() != n) d = WIDTH'($urandom);
    end
    check("b2b_grants", gid_q.size(), 5);
    for (int i = 1; i < gid_q.size(); i++)
      check("b2b_spacing", gcyc_q[i] - gcyc_q[i-1], WIDTH + 2);

    // Random traffic: requests held until granted, random backpressure.
    p0 = 0; p1 = 0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 600; i++) begin
      bit r;
      if (!p0 && ($urandom_range(0, 2) == 0)) begin p0 = 1; pd0 = WIDTH'($urandom); end
      if (!p1 && ($urandom_range(0, 2) == 0)) begin p1 = 1; pd1 = WIDTH'($urandom); end
      r = ($urandom_range(0, 199) == 0);
      n = gid_q.size();
      step(r, p0, p0 ? pd0 : WIDTH'($urandom), p1, p1 ? pd1 : WIDTH'($urandom),
           1'($urandom_range(0, 1)));
      if (gid_q.size() != n) begin
        if (gid_q[gid_q.size()-1] == 0) p0 = 0; else p1 = 0;
      end
    end
    check("rand_progress", (gid_q.size() > 20) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
